// File: rtl/osc_ctrl_receiver.sv
// -----------------------------------------------------------------------------
// osc_ctrl_receiver
//
// SPI-style serial control receiver for the DDS oscillator. A host shifts
// 24-bit frames (W, 7-bit address, 16-bit data, MSB first) to load shadow
// registers, then writes COMMIT to copy every shadow to the active outputs on
// one clk edge. Read frames return the active value of the addressed register
// on miso. Also produces the phase-accumulator clock-enable from a
// programmable divider. Everything runs on clk; the serial pins are
// synchronized and edge-detected.
//
// Ports:
//   clk          system clock
//   rst          asynchronous, active-high reset
//   sclk         serial clock (asynchronous, <= clk/8)
//   cs_n         frame select, active low
//   mosi         serial data in, MSB first
//   miso         serial read data, updated on sclk falling edges
//   tuning_word  active tuning word
//   wave_select  active waveform select
//   modulation   active PWM modulation value
//   ce           oscillator clock-enable strobe
//   frame_err    one-cycle pulse when a malformed frame is discarded
// -----------------------------------------------------------------------------
module osc_ctrl_receiver #(
    parameter int unsigned m           = 12,
    parameter int unsigned TUNE_WIDTH  = 16,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  sclk,
    input  logic                  cs_n,
    input  logic                  mosi,
    output logic                  miso,
    output logic [TUNE_WIDTH-1:0] tuning_word,
    output logic [2:0]            wave_select,
    output logic [m-1:0]          modulation,
    output logic                  ce,
    output logic                  frame_err
);

    typedef enum logic [1:0] {StIdle, StShift, StApply, StErr} state_e;

    localparam logic [6:0] AddrTune   = 7'h00;
    localparam logic [6:0] AddrWave   = 7'h01;
    localparam logic [6:0] AddrMod    = 7'h02;
    localparam logic [6:0] AddrCeDiv  = 7'h03;
    localparam logic [6:0] AddrCommit = 7'h04;

    localparam logic [4:0] FrameBits  = 5'd24;
    localparam logic [4:0] AddrBits   = 5'd8;
    localparam logic [4:0] AddrLast   = 5'd7;
    localparam logic [4:0] CntMax     = 5'd31;

    localparam logic [m-1:0] ModReset = {1'b1, {(m-1){1'b0}}};

    // ---------------------------------------------------------------------
    // Pin synchronizers and edge detection
    // ---------------------------------------------------------------------
    logic [SYNC_STAGES-1:0] sclk_sync_q, cs_sync_q, mosi_sync_q;
    logic                   sclk_prev_q, cs_prev_q;
    logic                   sclk_s, cs_s, mosi_s;
    logic                   sclk_rise, sclk_fall, cs_rise, cs_fall;

    // cs_n chain resets low so that cs_n already low at reset release never
    // looks like a falling edge; only a fresh high-to-low transition opens a
    // frame. A spurious "rise" out of reset is ignored in IDLE.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sclk_sync_q <= '0;
            cs_sync_q   <= '0;
            mosi_sync_q <= '0;
            sclk_prev_q <= 1'b0;
            cs_prev_q   <= 1'b0;
        end else begin
            sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], sclk};
            cs_sync_q   <= {cs_sync_q[SYNC_STAGES-2:0], cs_n};
            mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], mosi};
            sclk_prev_q <= sclk_sync_q[SYNC_STAGES-1];
            cs_prev_q   <= cs_sync_q[SYNC_STAGES-1];
        end
    end

    assign sclk_s    = sclk_sync_q[SYNC_STAGES-1];
    assign cs_s      = cs_sync_q[SYNC_STAGES-1];
    assign mosi_s    = mosi_sync_q[SYNC_STAGES-1];
    assign sclk_rise = sclk_s & ~sclk_prev_q;
    assign sclk_fall = ~sclk_s & sclk_prev_q;
    assign cs_rise   = cs_s & ~cs_prev_q;
    assign cs_fall   = ~cs_s & cs_prev_q;

    // ---------------------------------------------------------------------
    // Frame FSM
    // ---------------------------------------------------------------------
    state_e      state_q, state_d;
    logic [4:0]  bit_cnt_q, cnt_inc, cnt_eff;
    logic [23:0] shift_q, shift_next;
    logic [15:0] rd_shift_q, rd_value;
    logic        miso_q;
    logic        frame_start, shift_en, apply;

    assign cnt_inc    = (bit_cnt_q == CntMax) ? bit_cnt_q : bit_cnt_q + 5'd1;
    // An sclk rise in the same cycle as the cs_n rise is counted first.
    assign cnt_eff    = sclk_rise ? cnt_inc : bit_cnt_q;
    assign shift_next = {shift_q[22:0], mosi_s};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        frame_start = 1'b0;
        shift_en    = 1'b0;
        apply       = 1'b0;
        frame_err   = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (cs_fall) begin
                    state_d     = StShift;
                    frame_start = 1'b1;
                end
            end
            StShift: begin
                shift_en = sclk_rise;
                if (cs_rise) begin
                    state_d = (cnt_eff == FrameBits) ? StApply : StErr;
                end
            end
            StApply: begin
                apply   = 1'b1;
                state_d = StIdle;
            end
            StErr: begin
                frame_err = 1'b1;
                state_d   = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    // Shift path, read-data load after the address byte, miso shifting.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bit_cnt_q  <= '0;
            shift_q    <= '0;
            rd_shift_q <= '0;
            miso_q     <= 1'b0;
        end else if (frame_start) begin
            bit_cnt_q  <= '0;
            shift_q    <= '0;
            rd_shift_q <= '0;
            miso_q     <= 1'b0;
        end else if (shift_en) begin
            bit_cnt_q <= cnt_inc;
            shift_q   <= shift_next;
            if (bit_cnt_q == AddrLast) begin
                rd_shift_q <= rd_value;
            end
        end else if (state_q == StShift && sclk_fall && bit_cnt_q >= AddrBits) begin
            miso_q     <= rd_shift_q[15];
            rd_shift_q <= {rd_shift_q[14:0], 1'b0};
        end
    end

    assign miso = (state_q == StShift) ? miso_q : 1'b0;

    // ---------------------------------------------------------------------
    // Register file
    // ---------------------------------------------------------------------
    logic [TUNE_WIDTH-1:0] tune_shadow_q, tune_q;
    logic [2:0]            wave_shadow_q, wave_q;
    logic [m-1:0]          mod_shadow_q, mod_q;
    logic [15:0]           ce_div_q, ce_cnt_q;
    logic                  ce_q;

    logic        wr_en;
    logic [6:0]  wr_addr;
    logic [15:0] wr_data;
    logic        wr_tune, wr_wave, wr_mod, wr_ce_div, wr_commit;

    assign wr_en     = apply & shift_q[23];
    assign wr_addr   = shift_q[22:16];
    assign wr_data   = shift_q[15:0];
    assign wr_tune   = wr_en && (wr_addr == AddrTune);
    assign wr_wave   = wr_en && (wr_addr == AddrWave);
    assign wr_mod    = wr_en && (wr_addr == AddrMod);
    assign wr_ce_div = wr_en && (wr_addr == AddrCeDiv);
    assign wr_commit = wr_en && (wr_addr == AddrCommit);

    // After the 8th bit, shift_next[6:0] holds the complete address.
    always_comb begin
        rd_value = '0;
        case (shift_next[6:0])
            AddrTune:  rd_value = 16'(tune_q);
            AddrWave:  rd_value = {13'd0, wave_q};
            AddrMod:   rd_value = 16'(mod_q);
            AddrCeDiv: rd_value = ce_div_q;
            default:   rd_value = '0;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tune_shadow_q <= '0;
            wave_shadow_q <= '0;
            mod_shadow_q  <= ModReset;
            tune_q        <= '0;
            wave_q        <= '0;
            mod_q         <= ModReset;
        end else begin
            if (wr_tune) tune_shadow_q <= wr_data[TUNE_WIDTH-1:0];
            if (wr_wave) wave_shadow_q <= wr_data[2:0];
            if (wr_mod)  mod_shadow_q  <= wr_data[m-1:0];
            if (wr_commit) begin
                tune_q <= tune_shadow_q;
                wave_q <= wave_shadow_q;
                mod_q  <= mod_shadow_q;
            end
        end
    end

    assign tuning_word = tune_q;
    assign wave_select = wave_q;
    assign modulation  = mod_q;

    // ---------------------------------------------------------------------
    // CE divider: ce is registered so it is low during reset and rises on
    // the first edge after release when CE_DIV = 0. A CE_DIV write restarts
    // the count, so the first pulse lands CE_DIV+1 cycles later.
    // ---------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ce_div_q <= '0;
            ce_cnt_q <= '0;
            ce_q     <= 1'b0;
        end else if (wr_ce_div) begin
            ce_div_q <= wr_data;
            ce_cnt_q <= '0;
            ce_q     <= 1'b0;
        end else if (ce_cnt_q == ce_div_q) begin
            ce_cnt_q <= '0;
            ce_q     <= 1'b1;
        end else begin
            ce_cnt_q <= ce_cnt_q + 16'd1;
            ce_q     <= 1'b0;
        end
    end

    assign ce = ce_q;

endmodule

// File: tb/tb_osc_ctrl_receiver.sv
// -----------------------------------------------------------------------------
// tb_osc_ctrl_receiver
//
// Directed bench for osc_ctrl_receiver. Expected output snapshots and expected
// miso read words are pushed to scoreboard queues as each frame is driven and
// popped once the frame has settled.
// -----------------------------------------------------------------------------
module tb_osc_ctrl_receiver;

    localparam int unsigned M    = 12;
    localparam int unsigned TW   = 16;
    localparam int          HALF = 6;   // sclk half period in clk cycles

    logic          clk = 1'b0;
    logic          rst;
    logic          sclk;
    logic          cs_n;
    logic          mosi;
    logic          miso;
    logic [TW-1:0] tuning_word;
    logic [2:0]    wave_select;
    logic [M-1:0]  modulation;
    logic          ce;
    logic          frame_err;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc = 0;
    int err_pulses = 0;
    int tune_chg_cyc = 0;
    int wave_chg_cyc = 0;
    logic [TW-1:0] prev_tune;
    logic [2:0]    prev_wave;
    logic [23:0]   rx_word;

    typedef struct packed {
        logic [15:0] tune;
        logic [2:0]  wave;
        logic [11:0] modv;
    } snap_t;

    snap_t       snap_q[$];
    logic [23:0] exp_rx_q[$];

    osc_ctrl_receiver #(
        .m           (M),
        .TUNE_WIDTH  (TW),
        .SYNC_STAGES (2)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .sclk        (sclk),
        .cs_n        (cs_n),
        .mosi        (mosi),
        .miso        (miso),
        .tuning_word (tuning_word),
        .wave_select (wave_select),
        .modulation  (modulation),
        .ce          (ce),
        .frame_err   (frame_err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (frame_err === 1'b1) err_pulses++;
        if (tuning_word !== prev_tune) tune_chg_cyc = cyc;
        if (wave_select !== prev_wave) wave_chg_cyc = cyc;
        prev_tune = tuning_word;
        prev_wave = wave_select;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: observed no finish, required finish before time limit");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] mk(input logic w, input logic [6:0] a,
                                       input logic [15:0] d);
        return {8'h00, w, a, d};
    endfunction

    task automatic expect_outputs(input logic [15:0] t, input logic [2:0] w,
                                  input logic [11:0] mv);
        snap_t s;
        s.tune = t;
        s.wave = w;
        s.modv = mv;
        snap_q.push_back(s);
    endtask

    task automatic check_outputs(input string tag);
        snap_t s;
        if (snap_q.size() == 0) begin
            n_tests++;
            n_fail++;
            $error("FAIL %s: observed empty scoreboard, required a pending snapshot", tag);
        end else begin
            s = snap_q.pop_front();
            check({tag, "_tune"}, 32'(tuning_word), 32'(s.tune));
            check({tag, "_wave"}, 32'(wave_select), 32'(s.wave));
            check({tag, "_mod"},  32'(modulation),  32'(s.modv));
        end
    endtask

    task automatic clock_bit(input logic b);
        mosi = b;
        repeat (HALF) @(negedge clk);
        rx_word = {rx_word[22:0], miso};
        sclk = 1'b1;
        repeat (HALF) @(negedge clk);
        sclk = 1'b0;
    endtask

    // simul: raise cs_n together with the last sclk rise.
    task automatic frame(input logic [31:0] bits, input int n, input bit simul,
                         input int settle);
        rx_word = '0;
        cs_n = 1'b0;
        repeat (HALF) @(negedge clk);
        for (int i = n - 1; i >= 0; i--) begin
            mosi = bits[i];
            repeat (HALF) @(negedge clk);
            rx_word = {rx_word[22:0], miso};
            sclk = 1'b1;
            if (simul && i == 0) cs_n = 1'b1;
            repeat (HALF) @(negedge clk);
            sclk = 1'b0;
        end
        mosi = 1'b0;
        if (!simul) begin
            repeat (HALF) @(negedge clk);
            cs_n = 1'b1;
        end
        repeat (settle) @(negedge clk);
    endtask

    task automatic wr(input logic [6:0] a, input logic [15:0] d);
        frame(mk(1'b1, a, d), 24, 1'b0, 12);
    endtask

    task automatic rd(input string tag, input logic [6:0] a, input logic [15:0] exp_data);
        logic [23:0] e;
        exp_rx_q.push_back({8'h00, exp_data});
        frame(mk(1'b0, a, 16'h0000), 24, 1'b0, 12);
        e = exp_rx_q.pop_front();
        check(tag, 32'(rx_word), 32'(e));
    endtask

    initial begin
        int hi;
        int k;
        int n;
        logic [31:0] bits;

        rst  = 1'b1;
        sclk = 1'b0;
        cs_n = 1'b1;
        mosi = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_ce", 32'(ce), 32'd0);
        check("rst_tune", 32'(tuning_word), 32'h0000);
        check("rst_wave", 32'(wave_select), 32'd0);
        check("rst_mod", 32'(modulation), 32'h800);
        check("rst_frame_err", 32'(frame_err), 32'd0);
        check("rst_miso", 32'(miso), 32'd0);

        rst = 1'b0;
        hi = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (ce === 1'b1) hi++;
        end
        check("ce_every_cycle", 32'(hi), 32'd4);

        // Shadow writes do not reach outputs until COMMIT.
        expect_outputs(16'h0000, 3'd0, 12'h800);
        wr(7'h00, 16'h1234);
        check_outputs("tune_shadow");
        expect_outputs(16'h0000, 3'd0, 12'h800);
        wr(7'h01, 16'h0003);
        check_outputs("wave_shadow");
        expect_outputs(16'h1234, 3'd3, 12'h800);
        wr(7'h04, 16'h0000);
        check_outputs("commit");
        check("commit_same_edge", 32'(tune_chg_cyc), 32'(wave_chg_cyc));

        // Read back active TUNE; no side effects.
        expect_outputs(16'h1234, 3'd3, 12'h800);
        rd("read_tune", 7'h00, 16'h1234);
        check_outputs("read_no_effect");

        // CE_DIV = 4: first pulse 5 cycles after APPLY, then every 5.
        frame(mk(1'b1, 7'h03, 16'h0004), 24, 1'b0, 0);
        k = 0;
        while (ce !== 1'b0 && k < 20) begin
            @(negedge clk);
            k++;
        end
        check("ce_apply_seen", 32'(k < 20), 32'd1);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (ce !== 1'b1 && n < 20);
        check("ce_first_gap", 32'(n), 32'd5);
        @(negedge clk);
        check("ce_pulse_width", 32'(ce), 32'd0);
        n = 1;
        while (ce !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("ce_period", 32'(n), 32'd5);
        repeat (12) @(negedge clk);
        rd("read_ce_div", 7'h03, 16'h0004);

        // Malformed frames: 23 and 25 bits of a TUNE=0xFFFF write.
        bits = mk(1'b1, 7'h00, 16'hFFFF);
        expect_outputs(16'h1234, 3'd3, 12'h800);
        frame(bits >> 1, 23, 1'b0, 12);
        check_outputs("short_frame");
        check("short_err", 32'(err_pulses), 32'd1);
        expect_outputs(16'h1234, 3'd3, 12'h800);
        frame(bits << 1, 25, 1'b0, 12);
        check_outputs("long_frame");
        check("long_err", 32'(err_pulses), 32'd2);
        expect_outputs(16'h1234, 3'd3, 12'h800);
        wr(7'h04, 16'h0000);
        check_outputs("commit_after_err");

        // cs_n rising together with the 24th sclk rise still completes.
        expect_outputs(16'h1234, 3'd3, 12'h800);
        frame(mk(1'b1, 7'h02, 16'h00AB), 24, 1'b1, 12);
        check_outputs("simul_mod_shadow");
        check("simul_err", 32'(err_pulses), 32'd2);
        expect_outputs(16'h1234, 3'd3, 12'h0AB);
        wr(7'h04, 16'h0000);
        check_outputs("commit_mod");
        expect_outputs(16'h1234, 3'd3, 12'h0AB);
        wr(7'h04, 16'hFFFF);
        check_outputs("commit_unchanged");
        rd("read_commit", 7'h04, 16'h0000);

        // Reset after 12 bits of a TUNE write; cs_n stays low through release.
        bits = mk(1'b1, 7'h00, 16'hBEEF);
        rx_word = '0;
        cs_n = 1'b0;
        repeat (HALF) @(negedge clk);
        for (int i = 23; i >= 12; i--) clock_bit(bits[i]);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check("midrst_tune", 32'(tuning_word), 32'h0000);
        rst = 1'b0;
        for (int i = 11; i >= 0; i--) clock_bit(bits[i]);
        repeat (HALF) @(negedge clk);
        cs_n = 1'b1;
        repeat (12) @(negedge clk);
        expect_outputs(16'h0000, 3'd0, 12'h800);
        check_outputs("abort");
        check("abort_err", 32'(err_pulses), 32'd2);

        expect_outputs(16'h0000, 3'd0, 12'h800);
        wr(7'h00, 16'h5678);
        check_outputs("post_rst_shadow");
        rd("read_active_not_shadow", 7'h00, 16'h0000);
        expect_outputs(16'h5678, 3'd0, 12'h800);
        wr(7'h04, 16'h0000);
        check_outputs("post_rst_commit");
        check("final_err", 32'(err_pulses), 32'd2);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/osc_ctrl_receiver.md
Name: osc_ctrl_receiver

Overview:
- SPI-style serial control receiver that writes the oscillator's control inputs: tuning_word, wave_select, modulation and the CE strobe.
- Sits between the chip pins and the DDS oscillator.
- An external host loads shadow registers over a 24-bit frame, then commits them atomically to the active outputs.
- Also generates the phase-accumulator clock-enable from a programmable divider.

Parameters:
- m, 12: modulation width; must match the oscillator waveform width.
- TUNE_WIDTH, 16: tuning word width, 16 max.
- SYNC_STAGES, 2: synchronizer depth for sclk/cs_n/mosi, minimum 2.

Ports:
- clk  input  1  system clock.
- rst  input  1  asynchronous, active-high reset.
- sclk  input  1  serial clock, asynchronous to clk; frequency ≤ clk/8.
- cs_n  input  1  frame select, active low.
- mosi  input  1  serial data in, MSB first.
- miso  output  1  serial read data.
- tuning_word  output  TUNE_WIDTH  active tuning word.
- wave_select  output  3  active waveform select.
- modulation  output  m  active PWM modulation value.
- ce  output  1  oscillator clock-enable strobe.
- frame_err  output  1  one-cycle pulse when a malformed frame is discarded.

Behaviour:
- **Synchronization:** sclk, cs_n and mosi each pass through SYNC_STAGES flops. Rising and falling edges of sclk and cs_n are detected in the clk domain. All logic runs on clk only.
- **Frame format (24 bits, MSB first):**
  - bit23: W (1 = write, 0 = read).
  - bits22:16: 7-bit address.
  - bits15:0: data.
  - mosi is sampled on each synchronized sclk rising edge.
- **FSM states:**
  - IDLE → SHIFT on cs_n falling edge; bit counter cleared.
  - SHIFT: each sclk rise shifts one bit and increments a 5-bit saturating counter.
  - SHIFT → APPLY on cs_n rising edge with count == 24.
  - SHIFT → ERR on cs_n rising edge with count != 24 (includes more than 24 bits).
  - APPLY: one cycle; performs the write if W = 1, then → IDLE.
  - ERR: one cycle; frame_err = 1, frame discarded, then → IDLE.
- **Register map:**
  - 0x00 TUNE: shadow tuning word, data[TUNE_WIDTH-1:0].
  - 0x01 WAVE: shadow wave_select, data[2:0].
  - 0x02 MOD: shadow modulation, data[m-1:0].
  - 0x03 CE_DIV: 16 bits, written directly to active (no shadow).
  - 0x04 COMMIT: a write of any data copies all three shadows to tuning_word/wave_select/modulation in the same clk edge.
  - Writes to other addresses are ignored without error.
- **Write timing:** outputs change on the clk edge that ends APPLY, i.e. a bounded number of clk cycles after the physical cs_n rise (synchronizer depth + edge detect + 1).
- **Reads:**
  - After the 8th bit (address complete), the active value of the addressed register is loaded into a 16-bit read shift register, zero-extended.
  - Reading TUNE/WAVE/MOD returns the active value, not the shadow.
  - COMMIT and unmapped addresses read 0.
  - miso presents bit15 of the read data on the 8th sclk falling edge and shifts on each subsequent falling edge, so the host samples on rising edges.
  - miso = 0 outside SHIFT and during bits 23:16.
  - A read frame with W = 0 has no side effects.
- **CE generator:**
  - 16-bit counter. When counter == CE_DIV: ce = 1 for one cycle and the counter reloads 0; otherwise the counter increments.
  - CE_DIV = 0 gives ce = 1 every cycle.
  - A write to CE_DIV resets the counter to 0 in the same cycle.
- **Reset values (asynchronous):**
  - All outputs and shadows: tuning_word = 0, wave_select = 0, modulation = 2^(m-1) (50% duty).
  - CE_DIV = 0, counter = 0.
  - ce = 0 while rst is high; ce goes high the first cycle after release.
  - miso = 0, frame_err = 0, FSM = IDLE.
- **Boundary conditions:**
  - **rst mid-frame:** frame abandoned, no write.
  - **cs_n low at reset release:** FSM remains IDLE until a fresh cs_n falling edge.
  - **Simultaneous cs_n rise and sclk rise:** the sclk bit is counted first.
  - **COMMIT with unchanged shadows:** outputs unchanged.

Test Plan:
- Reset → tuning_word = 0x0000, wave_select = 0, modulation = 0x800, ce high every cycle, frame_err = 0.
- Write TUNE = 0x1234, then WAVE = 3 → outputs still 0/0. Then write COMMIT → tuning_word = 0x1234 and wave_select = 3 change on the same clk edge.
- Write CE_DIV = 4 → ce pulses exactly every 5 clk cycles, the first pulse 5 cycles after APPLY.
- After commit of 0x1234, read frame to address 0x00 (0x00_0000 shifted in) → miso bits 15:0 = 0x1234; no output changes.
- Frames of 23 bits and of 25 bits → frame_err pulses once per frame; all registers unchanged.
- Assert rst after 12 bits of a TUNE write frame, then release and send a full valid frame → the aborted write never appears and the new frame applies correctly.
